// File: rtl/four_bit_adder_sub.sv
// Registered WIDTH-bit adder/subtractor.
// mode=0 gives A+B with carry_out. mode=1 gives A-B with borrow_out.
// The result appears one clock after a qualified input is sampled.
module four_bit_adder_sub #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             mode,
  input  logic             in_valid,
  output logic [WIDTH-1:0] out,
  output logic             carry_out,
  output logic             borrow_out,
  output logic             out_valid
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] sum;
  logic             chain_c;

  // Ripple-carry chain of full-adder cells.
  // Subtraction uses the inverted B operand with a carry-in of 1 (two's complement).
  // The carry is carried as a block-local bit so the chain has no combinational self-loop on a vector.
  always_comb begin
    logic carry;
    b_eff = b_in ^ {WIDTH{mode}};
    sum   = '0;
    carry = mode;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      sum[i] = a_in[i] ^ b_eff[i] ^ carry;
      carry  = (a_in[i] & b_eff[i]) | (a_in[i] & carry) | (b_eff[i] & carry);
    end
    chain_c = carry;
  end

  // Result registers: reset has priority.
  // A valid input loads the registers. Idle cycles hold the result and drop out_valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out        <= '0;
      carry_out  <= 1'b0;
      borrow_out <= 1'b0;
      out_valid  <= 1'b0;
    end else if (in_valid) begin
      out        <= sum;
      carry_out  <= ~mode & chain_c;
      borrow_out <= mode & ~chain_c;
      out_valid  <= 1'b1;
    end else begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_four_bit_adder_sub.sv
// Self-checking bench for four_bit_adder_sub.
// It applies a directed boundary table, reset and idle sequences, an exhaustive sweep and random ops.
// All results are compared against an arithmetic reference model.
module tb_four_bit_adder_sub;

  localparam int unsigned W   = 4;
  localparam int unsigned MOD = 1 << W;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         mode;
  logic         in_valid;
  logic [W-1:0] out;
  logic         carry_out;
  logic         borrow_out;
  logic         out_valid;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  // Reference model state: what the outputs should hold after each edge.
  logic [W-1:0] m_out = '0;
  logic         m_c   = 1'b0;
  logic         m_b   = 1'b0;
  logic         m_v   = 1'b0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         m;
    logic [W-1:0] e_out;
    logic         e_c;
    logic         e_b;
  } vec_t;

  vec_t vecs[7];

  four_bit_adder_sub #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .a_in       (a_in),
    .b_in       (b_in),
    .mode       (mode),
    .in_valid   (in_valid),
    .out        (out),
    .carry_out  (carry_out),
    .borrow_out (borrow_out),
    .out_valid  (out_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else
      n_pass++;
  endtask

  // Plain arithmetic reference for one operation.
  function automatic void ref_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic m,
                                 output logic [W-1:0] o, output logic c, output logic bo);
    int unsigned s;
    if (!m) begin
      s  = int'(a) + int'(b);
      o  = W'(s % MOD);
      c  = (s >= MOD);
      bo = 1'b0;
    end else begin
      s  = int'(a) + MOD - int'(b);
      o  = W'(s % MOD);
      c  = 1'b0;
      bo = (a < b);
    end
  endfunction

  // Drives one cycle of inputs from a negedge and advances the model.
  // After the next negedge it checks all outputs against the model.
  task automatic step(input logic r, input logic v, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic m, input string tag);
    logic [W-1:0] o;
    logic         c, bo;
    rst_n = r; in_valid = v; a_in = a; b_in = b; mode = m;
    if (!r) begin
      m_out = '0; m_c = 1'b0; m_b = 1'b0; m_v = 1'b0;
    end else if (v) begin
      ref_op(a, b, m, o, c, bo);
      m_out = o; m_c = c; m_b = bo; m_v = 1'b1;
    end else begin
      m_v = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    check({tag, ".out"},        32'(out),        32'(m_out));
    check({tag, ".carry_out"},  32'(carry_out),  32'(m_c));
    check({tag, ".borrow_out"}, 32'(borrow_out), 32'(m_b));
    check({tag, ".out_valid"},  32'(out_valid),  32'(m_v));
    check({tag, ".flags_excl"}, 32'(carry_out & borrow_out), 32'(0));
  endtask

  initial begin
    vecs[0] = '{a: 4'd9,  b: 4'd9,  m: 1'b0, e_out: 4'd2,  e_c: 1'b1, e_b: 1'b0};
    vecs[1] = '{a: 4'd15, b: 4'd1,  m: 1'b0, e_out: 4'd0,  e_c: 1'b1, e_b: 1'b0};
    vecs[2] = '{a: 4'd7,  b: 4'd8,  m: 1'b0, e_out: 4'd15, e_c: 1'b0, e_b: 1'b0};
    vecs[3] = '{a: 4'd3,  b: 4'd5,  m: 1'b1, e_out: 4'd14, e_c: 1'b0, e_b: 1'b1};
    vecs[4] = '{a: 4'd5,  b: 4'd3,  m: 1'b1, e_out: 4'd2,  e_c: 1'b0, e_b: 1'b0};
    vecs[5] = '{a: 4'd0,  b: 4'd15, m: 1'b1, e_out: 4'd1,  e_c: 1'b0, e_b: 1'b1};
    vecs[6] = '{a: 4'd6,  b: 4'd6,  m: 1'b1, e_out: 4'd0,  e_c: 1'b0, e_b: 1'b0};

    rst_n = 1'b0; in_valid = 1'b1; a_in = 4'd9; b_in = 4'd9; mode = 1'b0;
    @(negedge clk);

    // Reset held for two cycles with a valid op pending.
    step(1'b0, 1'b1, 4'd9, 4'd9, 1'b0, "reset0");
    step(1'b0, 1'b1, 4'd9, 4'd9, 1'b0, "reset1");
    // First op after release.
    step(1'b1, 1'b1, 4'd9, 4'd9, 1'b0, "first");
    check("first.out_const", 32'(out), 32'(2));

    // Directed boundary table, applied back-to-back.
    for (int i = 0; i < 7; i++) begin
      step(1'b1, 1'b1, vecs[i].a, vecs[i].b, vecs[i].m, "table");
      check("table.out_const",    32'(out),        32'(vecs[i].e_out));
      check("table.carry_const",  32'(carry_out),  32'(vecs[i].e_c));
      check("table.borrow_const", 32'(borrow_out), 32'(vecs[i].e_b));
    end

    // Valid gating: idle cycles with unknown inputs hold the result.
    step(1'b1, 1'b1, 4'd4, 4'd2, 1'b0, "gate_op");
    step(1'b1, 1'b0, 'x, 'x, 1'bx, "gate_idle0");
    check("gate_idle0.out_const", 32'(out), 32'(6));
    step(1'b1, 1'b0, 4'(W'($urandom)), 4'(W'($urandom)), 1'($urandom), "gate_idle1");
    step(1'b1, 1'b0, 'x, 'x, 1'bx, "gate_idle2");
    check("gate_idle2.out_const", 32'(out), 32'(6));

    // Exhaustive sweep. Mode toggles every cycle, with no bubbles.
    for (int unsigned a = 0; a < MOD; a++)
      for (int unsigned b = 0; b < MOD; b++)
        for (int unsigned m = 0; m < 2; m++)
          step(1'b1, 1'b1, W'(a), W'(b), 1'(m), "sweep");

    // Mid-stream reset drops the op sampled at the reset edge.
    step(1'b1, 1'b1, 4'd12, 4'd7, 1'b0, "mid_op0");
    step(1'b1, 1'b1, 4'd2,  4'd9, 1'b1, "mid_op1");
    step(1'b0, 1'b1, 4'd15, 4'd15, 1'b0, "mid_rst");
    step(1'b1, 1'b0, 4'd1,  4'd1, 1'b0, "mid_after");
    check("mid_after.out_const", 32'(out), 32'(0));

    // Random ops with random valid gaps.
    for (int i = 0; i < 300; i++)
      step(1'b1, 1'($urandom_range(0, 3) != 0), W'($urandom), W'($urandom), 1'($urandom), "rand");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
